// File: rtl/demux_stream_dispatcher_if.sv
// Stream bundle for demux_stream_dispatcher: one upstream valid/ready port and
// four downstream channel ports. The dispatcher uses "slave"; the environment uses "master".
interface demux_stream_dispatcher_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Valid_In;
    logic                  Ready_Out;
    logic [DATA_WIDTH-1:0] Data_In;
    logic [1:0]            Select_In;

    logic [DATA_WIDTH-1:0] Data_0_Out;
    logic [DATA_WIDTH-1:0] Data_1_Out;
    logic [DATA_WIDTH-1:0] Data_2_Out;
    logic [DATA_WIDTH-1:0] Data_3_Out;
    logic                  Valid_0_Out;
    logic                  Valid_1_Out;
    logic                  Valid_2_Out;
    logic                  Valid_3_Out;
    logic                  Ready_0_In;
    logic                  Ready_1_In;
    logic                  Ready_2_In;
    logic                  Ready_3_In;

    modport master (
        output Valid_In, Data_In, Select_In,
        output Ready_0_In, Ready_1_In, Ready_2_In, Ready_3_In,
        input  Ready_Out,
        input  Data_0_Out, Data_1_Out, Data_2_Out, Data_3_Out,
        input  Valid_0_Out, Valid_1_Out, Valid_2_Out, Valid_3_Out
    );

    modport slave (
        input  Valid_In, Data_In, Select_In,
        input  Ready_0_In, Ready_1_In, Ready_2_In, Ready_3_In,
        output Ready_Out,
        output Data_0_Out, Data_1_Out, Data_2_Out, Data_3_Out,
        output Valid_0_Out, Valid_1_Out, Valid_2_Out, Valid_3_Out
    );
endinterface

// File: rtl/demux_stream_dispatcher.sv
// Registered 1:4 stream demultiplexer with per-channel one-word holding registers,
// addressed or burst round-robin steering, and per-channel valid/ready back-pressure.
module demux_stream_dispatcher #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic       Clock_In,
    input  logic       Reset_N_In,
    input  logic       Enable_In,
    input  logic       Mode_In,
    output logic [1:0] Channel_Out,
    demux_stream_dispatcher_if.slave bus
);

    localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] chan_data [4];
    logic [3:0]            chan_valid;
    logic [3:0]            chan_ready;
    logic [7:0]            burst_count;
    logic [1:0]            target;
    logic                  accept;

    assign chan_ready = {bus.Ready_3_In, bus.Ready_2_In, bus.Ready_1_In, bus.Ready_0_In};

    always_comb begin
        target = Mode_In ? Channel_Out : bus.Select_In;
    end

    // A full target whose consumer is ready can take a new word on the same edge it drains.
    assign bus.Ready_Out = Enable_In & (~chan_valid[target] | chan_ready[target]);
    assign accept        = bus.Valid_In & bus.Ready_Out;

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            chan_valid <= '0;
            for (int n = 0; n < 4; n++) begin
                chan_data[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (accept && (target == 2'(n))) begin
                    chan_data[n]  <= bus.Data_In;
                    chan_valid[n] <= 1'b1;
                end else if (chan_valid[n] && chan_ready[n]) begin
                    chan_valid[n] <= 1'b0;
                end
            end
        end
    end

    // Addressed mode parks the pointer so every round-robin entry starts a fresh burst on channel 0.
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            Channel_Out <= 2'd0;
            burst_count <= 8'd0;
        end else if (!Mode_In) begin
            Channel_Out <= 2'd0;
            burst_count <= 8'd0;
        end else if (accept) begin
            if (burst_count == BURST_LAST) begin
                burst_count <= 8'd0;
                Channel_Out <= Channel_Out + 2'd1;
            end else begin
                burst_count <= burst_count + 8'd1;
            end
        end
    end

    assign bus.Data_0_Out  = chan_data[0];
    assign bus.Data_1_Out  = chan_data[1];
    assign bus.Data_2_Out  = chan_data[2];
    assign bus.Data_3_Out  = chan_data[3];
    assign bus.Valid_0_Out = chan_valid[0];
    assign bus.Valid_1_Out = chan_valid[1];
    assign bus.Valid_2_Out = chan_valid[2];
    assign bus.Valid_3_Out = chan_valid[3];

endmodule
